// File: rtl/i2c_decoder_pkg.sv
// Shared types for the passive I2C bus decoder: event encoding, record
// layout, FSM state codes and small helpers used by the RTL and the bench.
package i2c_decoder_pkg;

    // Record payload width; the decoder top is instantiated with a matching
    // I2C_DATA_WIDTH.
    localparam int EVT_DATA_W = 8;

    typedef enum logic [2:0] {
        EVT_START  = 3'd0,
        EVT_RSTART = 3'd1,
        EVT_ADDR   = 3'd2,
        EVT_DATA   = 3'd3,
        EVT_STOP   = 3'd4
    } i2c_evt_t;

    // Meaning of the last bit of an address byte.
    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } i2c_op_t;

    typedef struct packed {
        i2c_evt_t                evt_type;
        logic [EVT_DATA_W-1:0]   data;
        logic                    ack;
        logic                    err;
    } i2c_evt_rec_t;

    localparam int EVT_REC_W = $bits(i2c_evt_rec_t);

    // Decoder FSM state codes (also visible on the debug output).
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_DATA_ACK = 3'd4;

    function automatic i2c_evt_rec_t make_rec(input i2c_evt_t t,
                                              input logic [EVT_DATA_W-1:0] d,
                                              input logic a,
                                              input logic e);
        i2c_evt_rec_t r;
        r.evt_type = t;
        r.data     = d;
        r.ack      = a;
        r.err      = e;
        return r;
    endfunction

    function automatic i2c_op_t addr_op(input logic [EVT_DATA_W-1:0] addr_byte);
        return i2c_op_t'(addr_byte[0]);
    endfunction

endpackage

// File: rtl/i2c_evt_fifo.sv
// Synchronous FIFO of decoder event records. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is
// refused and the caller decides what to do with it.
module i2c_evt_fifo
    import i2c_decoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  i2c_evt_rec_t             rec_i,
    input  logic                     pop_i,
    output i2c_evt_rec_t             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    i2c_evt_rec_t     mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy update; pointers wrap naturally (power-of-2 depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end

    // Control registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are meaningless while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= rec_i;
    end

endmodule

// File: rtl/i2c_bus_decoder.sv
// Passive I2C decoder: synchronises SCL/SDA, detects START/STOP/bit samples
// and emits byte-level event records through a FIFO-backed stream.
// Stream handshake: evt_valid_o is high whenever a record is at the FIFO head;
// the head is consumed on a rising clk_i edge where evt_valid_o and
// evt_ready_i are both high, and all evt_* outputs stay stable until then.
module i2c_bus_decoder
    import i2c_decoder_pkg::*;
#(
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      evt_valid_o,
    input  logic                      evt_ready_i,
    output logic [2:0]                evt_type_o,
    output logic [I2C_DATA_WIDTH-1:0] evt_data_o,
    output logic                      evt_ack_o,
    output logic                      evt_err_o,
    output logic                      bus_busy_o,
    output logic                      ovf_o,
    input  logic                      ovf_clr_i,
    output logic [2:0]                state_dbg_o
);
    localparam int CNT_W = $clog2(I2C_DATA_WIDTH + 2);

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_q, sda_q, scl_s, sda_s;
    logic       start_det, stop_det, sample, scl_fall;

    logic [2:0]                state_q, state_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [I2C_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                      busy_q, busy_d;
    logic                      pend_q, pend_d;
    logic                      ovf_q, ovf_d;
    logic                      push, trunc;
    i2c_evt_rec_t              push_rec;

    i2c_evt_rec_t                  fifo_head;
    logic                          fifo_full, fifo_empty, fifo_pop, overflow;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    // Two-flop synchronisers plus one history stage; preset to an idle bus.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_q      <= scl_sync_q[1];
            sda_q      <= sda_sync_q[1];
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    // Requiring SCL high in both stages suppresses START/STOP on a
    // simultaneous SCL/SDA change.
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
    assign sample    = ~scl_q & scl_s;
    assign scl_fall  = scl_q & ~scl_s;

    // The SCL rise that opens a START/STOP condition is sampled like any bit;
    // pend_q marks it so it does not count as a partial data bit.
    assign trunc = (bit_cnt_q > {{(CNT_W-1){1'b0}}, pend_q});

    // Decoder FSM: state, bit counter, shift register and record generation.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        busy_d    = busy_q;
        pend_d    = pend_q;
        push      = 1'b0;
        push_rec  = make_rec(EVT_START, '0, 1'b0, 1'b0);
        if (sample)        pend_d = 1'b1;
        else if (scl_fall) pend_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start_det) begin
                push      = 1'b1;
                busy_d    = 1'b1;
                state_d   = ST_ADDR;
                bit_cnt_d = '0;
            end
        end else if (start_det) begin
            push      = 1'b1;
            push_rec  = make_rec(EVT_RSTART, '0, 1'b0, trunc);
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
        end else if (stop_det) begin
            push      = 1'b1;
            push_rec  = make_rec(EVT_STOP, '0, 1'b0, trunc);
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
        end else if (sample) begin
            case (state_q)
                ST_ADDR, ST_DATA: begin
                    shift_d = {shift_q[I2C_DATA_WIDTH-2:0], sda_s};
                    if ((state_q == ST_ADDR && bit_cnt_q == CNT_W'(I2C_ADDR_WIDTH)) ||
                        (state_q == ST_DATA && bit_cnt_q == CNT_W'(I2C_DATA_WIDTH - 1))) begin
                        state_d   = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                ST_ADDR_ACK: begin
                    push      = 1'b1;
                    push_rec  = make_rec(EVT_ADDR,
                                         EVT_DATA_W'(shift_q[I2C_ADDR_WIDTH:0]),
                                         ~sda_s, 1'b0);
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
                ST_DATA_ACK: begin
                    push      = 1'b1;
                    push_rec  = make_rec(EVT_DATA, EVT_DATA_W'(shift_q), ~sda_s, 1'b0);
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign fifo_pop = evt_ready_i & ~fifo_empty;
    assign overflow = push & fifo_full & ~fifo_pop;

    // Sticky overflow flag; a new overflow beats a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr_i) ovf_d = 1'b0;
        if (overflow)  ovf_d = 1'b1;
    end

    // Decoder state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            pend_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
        end
    end

    i2c_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .rec_i   (push_rec),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Record fields read as zero whenever no record is presented.
    assign evt_valid_o = (fifo_count != '0);
    assign evt_type_o  = evt_valid_o ? fifo_head.evt_type : 3'd0;
    assign evt_data_o  = evt_valid_o ? fifo_head.data : '0;
    assign evt_ack_o   = evt_valid_o & fifo_head.ack;
    assign evt_err_o   = evt_valid_o & fifo_head.err;
    assign bus_busy_o  = busy_q;
    assign ovf_o       = ovf_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_i2c_bus_decoder.sv
// Bench for i2c_bus_decoder: drives I2C waveforms on the pins, predicts the
// record stream into a queue and checks every record the DUT hands over.
module tb_i2c_bus_decoder;
    import i2c_decoder_pkg::*;

    localparam int W = EVT_REC_W;
    localparam int H = 4;  // clk cycles per quarter SCL period

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       scl = 1'b1, sda = 1'b1, evt_ready = 1'b0, ovf_clr = 1'b0;
    logic       evt_valid, evt_ack, evt_err, bus_busy, ovf;
    logic [2:0] evt_type, state_dbg;
    logic [7:0] evt_data;

    i2c_bus_decoder #(.I2C_ADDR_WIDTH(7), .I2C_DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .scl_i       (scl),
        .sda_i       (sda),
        .evt_valid_o (evt_valid),
        .evt_ready_i (evt_ready),
        .evt_type_o  (evt_type),
        .evt_data_o  (evt_data),
        .evt_ack_o   (evt_ack),
        .evt_err_o   (evt_err),
        .bus_busy_o  (bus_busy),
        .ovf_o       (ovf),
        .ovf_clr_i   (ovf_clr),
        .state_dbg_o (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int busy_drops = 0;
    logic busy_watch = 1'b0;

    function automatic logic [W-1:0] rec(input logic [2:0] t, input logic [7:0] d,
                                         input logic a, input logic e);
        return {t, d, a, e};
    endfunction

    // Inputs change 2 ns after posedge, so negedge values are what the next
    // posedge will see: a record here with ready high is consumed next edge.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            logic [W-1:0] got, exp;
            got = {evt_type, evt_data, evt_ack, evt_err};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL record_unexpected got=%h required=none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("FAIL record got=%h required=%h (type,data,ack,err)", got, exp);
                end
            end
        end
        if (busy_watch && !bus_busy) busy_drops++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic i2c_start();
        sda = 1'b1; step(H);
        scl = 1'b1; step(H);
        sda = 1'b0; step(H);
        scl = 1'b0; step(H);
    endtask

    task automatic i2c_bit(input logic b);
        sda = b;    step(H);
        scl = 1'b1; step(2 * H);
        scl = 1'b0; step(H);
    endtask

    task automatic i2c_stop();
        sda = 1'b0; step(H);
        scl = 1'b1; step(H);
        sda = 1'b1; step(H);
    endtask

    // ack = 1 means SDA is held low on the 9th clock.
    task automatic send_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
        i2c_bit(~ack);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !evt_valid) break;
            step(1);
        end
        total++;
        if (exp_q.size() != 0 || evt_valid) begin
            bad++;
            $display("FAIL %s_drain pending=%0d valid=%b required pending=0 valid=0",
                     name, exp_q.size(), evt_valid);
            exp_q.delete();
        end
    endtask

    task automatic run_write();
        exp_q.push_back(rec(EVT_START, 8'h00, 1'b0, 1'b0));
        exp_q.push_back(rec(EVT_ADDR, 8'hA0, 1'b1, 1'b0));
        exp_q.push_back(rec(EVT_DATA, 8'hA5, 1'b1, 1'b0));
        exp_q.push_back(rec(EVT_STOP, 8'h00, 1'b0, 1'b0));
        busy_drops = 0;
        i2c_start();
        busy_watch = 1'b1;
        send_byte(8'hA0, 1'b1);
        send_byte(8'hA5, 1'b1);
        busy_watch = 1'b0;
        i2c_stop();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; scl = 1'b1; sda = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
        step(3);
        total++;
        if ({evt_valid, evt_type, evt_data, evt_ack, evt_err, bus_busy, ovf} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b required=0",
                     {evt_valid, evt_type, evt_data, evt_ack, evt_err, bus_busy, ovf});
        end
        total++;
        if (state_dbg !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state got=%0d required=%0d", state_dbg, ST_IDLE);
        end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_latency();
        evt_ready = 1'b0;
        exp_q.push_back(rec(EVT_START, 8'h00, 1'b0, 1'b0));
        exp_q.push_back(rec(EVT_STOP, 8'h00, 1'b0, 1'b0));
        sda = 1'b0;
        step(2);
        total++;
        if (evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_early valid=%b required=0", evt_valid);
        end
        step(1);
        total++;
        if (evt_valid !== 1'b1 || bus_busy !== 1'b1) begin
            bad++;
            $display("FAIL latency_edge3 valid=%b busy=%b required 1 1", evt_valid, bus_busy);
        end
        step(H);
        sda = 1'b1;  // STOP straight after START: no bits, so no error
        step(H);
        evt_ready = 1'b1;
        wait_drain("latency");
    endtask

    task automatic test_write();
        evt_ready = 1'b1;
        run_write();
        wait_drain("write");
        total++;
        if (busy_drops != 0 || bus_busy !== 1'b0) begin
            bad++;
            $display("FAIL write_busy drops=%0d busy_after=%b required 0 0", busy_drops, bus_busy);
        end
    endtask

    task automatic test_read_nack();
        evt_ready = 1'b1;
        exp_q.push_back(rec(EVT_START, 8'h00, 1'b0, 1'b0));
        exp_q.push_back(rec(EVT_ADDR, 8'h79, 1'b1, 1'b0));
        exp_q.push_back(rec(EVT_DATA, 8'h12, 1'b1, 1'b0));
        exp_q.push_back(rec(EVT_DATA, 8'h34, 1'b0, 1'b0));
        exp_q.push_back(rec(EVT_STOP, 8'h00, 1'b0, 1'b0));
        i2c_start();
        send_byte({7'h3C, 1'b1}, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        i2c_stop();
        wait_drain("read_nack");
    endtask

    task automatic test_rstart();
        evt_ready = 1'b1;
        exp_q.push_back(rec(EVT_START, 8'h00, 1'b0, 1'b0));
        exp_q.push_back(rec(EVT_ADDR, 8'hA0, 1'b1, 1'b0));
        exp_q.push_back(rec(EVT_DATA, 8'h01, 1'b1, 1'b0));
        exp_q.push_back(rec(EVT_RSTART, 8'h00, 1'b0, 1'b0));
        exp_q.push_back(rec(EVT_ADDR, 8'hA1, 1'b1, 1'b0));
        exp_q.push_back(rec(EVT_DATA, 8'hFF, 1'b0, 1'b0));
        exp_q.push_back(rec(EVT_STOP, 8'h00, 1'b0, 1'b0));
        busy_drops = 0;
        i2c_start();
        busy_watch = 1'b1;
        send_byte(8'hA0, 1'b1);
        send_byte(8'h01, 1'b1);
        i2c_start();
        send_byte(8'hA1, 1'b1);
        send_byte(8'hFF, 1'b0);
        busy_watch = 1'b0;
        i2c_stop();
        wait_drain("rstart");
        total++;
        if (busy_drops != 0) begin
            bad++;
            $display("FAIL rstart_busy drops=%0d required=0", busy_drops);
        end
    endtask

    task automatic test_truncated();
        evt_ready = 1'b1;
        exp_q.push_back(rec(EVT_START, 8'h00, 1'b0, 1'b0));
        exp_q.push_back(rec(EVT_ADDR, 8'hA0, 1'b1, 1'b0));
        exp_q.push_back(rec(EVT_STOP, 8'h00, 1'b0, 1'b1));
        i2c_start();
        send_byte(8'hA0, 1'b1);
        i2c_bit(1'b1);
        i2c_bit(1'b0);
        i2c_bit(1'b1);
        i2c_stop();
        wait_drain("truncated");
        total++;
        if (state_dbg !== ST_IDLE || bus_busy !== 1'b0) begin
            bad++;
            $display("FAIL truncated_idle state=%0d busy=%b required %0d 0",
                     state_dbg, bus_busy, ST_IDLE);
        end
    endtask

    task automatic test_overflow();
        evt_ready = 1'b0;
        exp_q.push_back(rec(EVT_START, 8'h00, 1'b0, 1'b0));
        exp_q.push_back(rec(EVT_ADDR, 8'hA0, 1'b1, 1'b0));
        exp_q.push_back(rec(EVT_DATA, 8'hA5, 1'b1, 1'b0));
        exp_q.push_back(rec(EVT_DATA, 8'h55, 1'b1, 1'b0));
        i2c_start();
        send_byte(8'hA0, 1'b1);
        send_byte(8'hA5, 1'b1);
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_early got=%b required=0", ovf);
        end
        send_byte(8'h55, 1'b1);
        i2c_stop();
        step(4);
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set got=%b required=1", ovf);
        end
        total++;
        if ({evt_valid, evt_type, evt_data} !== {1'b1, 3'(EVT_START), 8'h00}) begin
            bad++;
            $display("FAIL ovf_head_hold got=%h required=%h",
                     {evt_valid, evt_type, evt_data}, {1'b1, 3'(EVT_START), 8'h00});
        end
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got=%b required=0", ovf);
        end
        evt_ready = 1'b1;
        wait_drain("overflow");
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b0;
        i2c_start();
        i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b0);
        total++;
        if (evt_valid !== 1'b1 || bus_busy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre valid=%b busy=%b required 1 1", evt_valid, bus_busy);
        end
        rst = 1'b1;
        step(2);
        total++;
        if ({evt_valid, evt_type, evt_data, evt_ack, evt_err, bus_busy, ovf} !== '0 ||
            state_dbg !== ST_IDLE) begin
            bad++;
            $display("FAIL rstmid_held outputs=%b state=%0d required 0 0",
                     {evt_valid, evt_type, evt_data, evt_ack, evt_err, bus_busy, ovf}, state_dbg);
        end
        rst = 1'b0;
        step(2);
        evt_ready = 1'b1;
        i2c_bit(1'b0); i2c_bit(1'b0); i2c_bit(1'b0); i2c_bit(1'b0);
        i2c_bit(1'b0);
        send_byte(8'hA5, 1'b1);
        step(10);
        total++;
        if (evt_valid !== 1'b0 || bus_busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_no_start valid=%b busy=%b required 0 0", evt_valid, bus_busy);
        end
        i2c_stop();  // STOP on an idle bus is ignored
        run_write();
        wait_drain("rstmid_fresh");
    endtask

    task automatic test_back_to_back();
        logic done;
        done = 1'b0;
        fork
            begin
                for (int t = 0; t < 3; t++) begin
                    logic [7:0] ab;
                    int nb;
                    ab = {7'($urandom_range(0, 127)), 1'($urandom_range(0, 1))};
                    nb = $urandom_range(1, 3);
                    exp_q.push_back(rec(EVT_START, 8'h00, 1'b0, 1'b0));
                    exp_q.push_back(rec(EVT_ADDR, ab, 1'b1, 1'b0));
                    i2c_start();
                    send_byte(ab, 1'b1);
                    for (int k = 0; k < nb; k++) begin
                        logic [7:0] d;
                        logic a;
                        d = 8'($urandom_range(0, 255));
                        a = 1'($urandom_range(0, 1));
                        exp_q.push_back(rec(EVT_DATA, d, a, 1'b0));
                        send_byte(d, a);
                    end
                    exp_q.push_back(rec(EVT_STOP, 8'h00, 1'b0, 1'b0));
                    i2c_stop();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    evt_ready = 1'($urandom_range(0, 1));
                    step(1);
                end
                evt_ready = 1'b1;
            end
        join
        wait_drain("back_to_back");
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ovf got=%b required=0", ovf);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_write();
        test_read_nack();
        test_rstart();
        test_truncated();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_bus_decoder.md
Name: i2c_bus_decoder

Overview:
- Synthesizable passive decoder on the I2C pins, downstream of the bus wires driven by the Wishbone-to-I2C bridge and the I2C slave BFM.
- Converts raw SCL/SDA into byte-level event records (START, repeated START, address, data, STOP) with ACK status.
- Buffers records in a small FIFO behind a valid/ready stream, so predictors and scoreboards consume bus activity independently of the BFM monitor task.
- Never drives the bus.

Parameters:
- I2C_ADDR_WIDTH, 7, address bits preceding the R/W bit.
- I2C_DATA_WIDTH, 8, bits per data byte.
- FIFO_DEPTH, 4, number of event records buffered; must be a power of 2, at least 2.

Ports:
- clk_i  in  1  system clock; must be at least 8x the SCL frequency.
- rst_i  in  1  asynchronous active-high reset.
- scl_i  in  1  raw SCL pin, asynchronous to clk_i.
- sda_i  in  1  raw SDA pin, asynchronous to clk_i.
- evt_valid_o  out  1  head record available.
- evt_ready_i  in  1  consumer accepts the head record.
- evt_type_o  out  3  0 START, 1 RSTART, 2 ADDR, 3 DATA, 4 STOP.
- evt_data_o  out  I2C_DATA_WIDTH  ADDR record: {addr, rw}; DATA record: byte MSB-first; 0 otherwise.
- evt_ack_o  out  1  1 when SDA was low at the 9th SCL rise.
- evt_err_o  out  1  record terminated a partial byte.
- bus_busy_o  out  1  high between START and STOP.
- ovf_o  out  1  sticky: a record was dropped.
- ovf_clr_i  in  1  one-cycle pulse that clears ovf_o.

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM in IDLE; both sync chains preset to 1 (idle bus).
- Synchronisation and edge detection:
  - scl_i and sda_i each pass through a 2-flop synchroniser to give scl_s and sda_s.
  - One further register stage gives scl_q and sda_q.
- Events, evaluated every clk_i:
  - START: scl_s = scl_q = 1 and sda_q = 1, sda_s = 0.
  - STOP: scl_s = scl_q = 1 and sda_q = 0, sda_s = 1.
  - Sample: scl_q = 0, scl_s = 1 (SCL rising); the sampled bit is sda_s.
  - If SCL and SDA change in the same cycle, START/STOP detection is suppressed; only the SCL edge is processed.
- FSM states and transitions:
  - IDLE: START -> push START record, set bus_busy_o, go to ADDR.
  - ADDR: shift I2C_ADDR_WIDTH+1 sampled bits into the shift register, then go to ADDR_ACK.
  - ADDR_ACK: next sample -> push ADDR record with evt_ack = ~sda_s, go to DATA.
  - DATA: shift I2C_DATA_WIDTH sampled bits, then go to DATA_ACK.
  - DATA_ACK: next sample -> push DATA record with its ack bit, return to DATA.
  - Bit counter resets on every state entry.
- STOP in any non-IDLE state:
  - Push a STOP record; evt_err = 1 if bit count is nonzero; clear bus_busy_o; go to IDLE.
  - STOP while in IDLE is ignored.
- START in any non-IDLE state:
  - Push an RSTART record; evt_err = 1 if bit count is nonzero; go to ADDR; bus_busy_o stays high.
- Latency:
  - A pin edge becomes a record in the FIFO at the 3rd clk_i rising edge after the edge.
  - evt_valid_o rises on the same edge when the FIFO was empty.
- Stream rules:
  - A record is popped when evt_valid_o and evt_ready_i are both high on a rising edge.
  - Outputs hold steady while evt_valid_o is high and evt_ready_i is low.
- FIFO full:
  - A push with no simultaneous pop drops the new record and sets ovf_o. Older records are kept.
  - Push and pop in the same cycle when full both succeed.
  - Pointers wrap modulo FIFO_DEPTH; a count register of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
- ovf_o:
  - Cleared by ovf_clr_i.
  - If ovf_clr_i and a new overflow occur in the same cycle, the set wins.
- Reset asserted mid-transfer: state, FIFO and flags clear immediately. Decoding resumes only at the next START.

Decomposition:
- Shared package i2c_decoder_pkg holds:
  - enum i2c_evt_t with the evt_type encoding above;
  - packed struct i2c_evt_rec_t {type, data, ack, err};
  - the shared enum i2c_op_t for R/W interpretation.
- Sub-module i2c_evt_fifo: parameterised synchronous FIFO of i2c_evt_rec_t, same clk/rst, with push/pop/full/empty/count.
- Synchronisers, edge detection and FSM stay in the top level.

Test Plan:
- Write transaction: START, addr 0x50 W, ACK, byte 0xA5 ACK, STOP, evt_ready_i = 1 -> records in order:
  - START;
  - ADDR data 0xA0, ack 1;
  - DATA 0xA5, ack 1;
  - STOP, err 0.
  - bus_busy_o high throughout the transfer.
- Read with master NACK: START, 0x3C R, bytes 0x12 ACK and 0x34 NACK, STOP -> records:
  - ADDR data 0x79, ack 1;
  - DATA 0x12, ack 1;
  - DATA 0x34, ack 0.
- Repeated START: write 0x50, byte 0x01, RSTART, 0x50 R, byte 0xFF NACK, STOP -> RSTART record err 0; bus_busy_o never drops between the two phases.
- Truncated byte: STOP after 3 data bits -> no DATA record; STOP record err 1; FSM back in IDLE.
- Overflow: hold evt_ready_i = 0 and run the write transaction (4 records) plus an extra byte 0x55, with FIFO_DEPTH = 4. Required response:
  - FIFO holds START, ADDR, DATA 0xA5, DATA 0x55;
  - STOP is dropped and ovf_o = 1;
  - ovf_clr_i pulse -> ovf_o = 0.
- Reset mid-byte: assert rst_i after 4 address bits. Required response:
  - outputs read 0 while rst_i is held;
  - after release, bits without a START produce no records;
  - a fresh START decodes normally.
